// File: rtl/pn_bit_source.sv
// ---------------------------------------------------------------------------
// pn_bit_source
//
// Serial pseudo-noise bit source. A WIDTH-bit word register is shifted out
// MSB first, one bit per bit period. The bit period is set at run time by a
// programmable divider. At every word boundary the word advances in one of
// three ways: a Fibonacci LFSR step (PN), no change (REPEAT) or a left
// rotate (ROTATE). An all-zero word reaching a PN advance is replaced by
// SEED, and this event is latched in a sticky lockup flag.
//
// Parameters
//   WIDTH   word / LFSR width (4..32)
//   TAPS    feedback mask, bit k set means word[k] is part of the XOR
//   SEED    reset and lockup-recovery word, must be nonzero
//   DIV_W   width of the bit-period divisor
//
// Ports
//   clk          in   single clock, all state updates on its rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   1 runs the divider and serializer, 0 freezes them
//   div          in   bit period minus one, in clk cycles
//   mode         in   00 PN, 01 REPEAT, 10 ROTATE, 11 behaves as PN
//   load         in   synchronous strobe that loads seed_in into the word
//   seed_in      in   word to load on load
//   bit_out      out  current serial code bit (registered)
//   bit_valid    out  one-cycle strobe for each new bit_out
//   frame_start  out  qualifies bit_valid for the first (MSB) bit of a word
//   word_out     out  word currently being serialized
//   lock_err     out  sticky all-zero lockup flag, cleared only by rst
// ---------------------------------------------------------------------------
module pn_bit_source #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'h8E,
   parameter logic [WIDTH-1:0] SEED  = 8'hAA,
   parameter int               DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic [WIDTH-1:0] word_out,
   output logic             lock_err
);

   localparam int               IDX_W   = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

   localparam logic [1:0] MODE_PN     = 2'b00;
   localparam logic [1:0] MODE_REPEAT = 2'b01;
   localparam logic [1:0] MODE_ROTATE = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   logic [WIDTH-1:0] word;
   logic [IDX_W-1:0] idx;
   logic [DIV_W-1:0] cnt;

   logic             tick;
   logic             pn_mode;
   logic             last_bit;
   logic             feedback;
   logic [WIDTH-1:0] advance_word;
   logic             lock_hit;
   logic [WIDTH-1:0] load_word;

   // The divider fires whenever the running count has reached or passed the
   // programmed period. Using >= rather than == means a period shortened
   // mid-count takes effect immediately instead of wrapping the counter.
   assign tick     = enable && (cnt >= div);

   // The reserved mode code behaves exactly like PN, so both are folded here.
   assign pn_mode  = (mode == MODE_PN) || (mode == MODE_RSVD);

   assign last_bit = (idx == '0);
   assign feedback = ^(word & TAPS);

   // Next word at a word boundary. In PN mode an all-zero word would lock
   // the LFSR forever, so it is replaced by SEED and the event is reported
   // through lock_hit so the sticky flag can latch it.
   always_comb begin
      advance_word = word;
      lock_hit     = 1'b0;
      case (mode)
         MODE_REPEAT: begin
            advance_word = word;
         end
         MODE_ROTATE: begin
            advance_word = {word[WIDTH-2:0], word[WIDTH-1]};
         end
         default: begin
            if (word == '0) begin
               advance_word = SEED;
               lock_hit     = 1'b1;
            end else begin
               advance_word = {word[WIDTH-2:0], feedback};
            end
         end
      endcase
   end

   // A zero seed is only dangerous for the LFSR, so it is swapped for SEED
   // in PN mode only; REPEAT and ROTATE may legitimately run an all-zero word.
   assign load_word = ((seed_in == '0) && pn_mode) ? SEED : seed_in;

   // Bit-period divider. A load restarts the period from zero so the first
   // bit of the freshly loaded word gets a full period. With enable low the
   // count is frozen so a paused word resumes with its remaining time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Word register and bit index. The index walks from the MSB down to bit
   // zero; after the last bit has been sent the word advances according to
   // the mode sampled on that same cycle and the index returns to the top.
   // A load takes priority over a coincident tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word <= SEED;
         idx  <= IDX_TOP;
      end else if (load) begin
         word <= load_word;
         idx  <= IDX_TOP;
      end else if (tick) begin
         if (last_bit) begin
            word <= advance_word;
            idx  <= IDX_TOP;
         end else begin
            idx  <= idx - IDX_W'(1);
         end
      end
   end

   // Serial output stage. bit_out keeps its last value between strobes (and
   // across a load), while bit_valid and frame_start are single-cycle pulses
   // that appear only on a tick that is not overridden by a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else if (load) begin
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else if (tick) begin
         bit_out     <= word[idx];
         bit_valid   <= 1'b1;
         frame_start <= (idx == IDX_TOP);
      end else begin
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
      end
   end

   // Sticky lockup flag. It records that the LFSR ever tried to advance from
   // an all-zero word; only a reset clears it, a later load does not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_err <= 1'b0;
      end else if (!load && tick && last_bit && lock_hit) begin
         lock_err <= 1'b1;
      end
   end

   assign word_out = word;

endmodule

// File: tb/tb_pn_bit_source.sv
// ---------------------------------------------------------------------------
// tb_pn_bit_source
//
// Self-checking bench for pn_bit_source at its default parameters. A
// behavioural model tracks the word, how many bits of it have been sent and
// how many cycles have elapsed in the current bit period, and predicts all
// outputs every cycle. Directed scenarios exercise the documented corner
// cases; a randomized phase then mixes enable, load, div, mode and seeds.
// ---------------------------------------------------------------------------
module tb_pn_bit_source;

   localparam int         WIDTH = 8;
   localparam logic [7:0] SEED  = 8'hAA;
   localparam int         TAPSV = 8'h8E;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] div;
   logic [1:0]  mode;
   logic        load;
   logic [7:0]  seedIn;
   logic        bitOut;
   logic        bitValid;
   logic        frameStart;
   logic [7:0]  wordOut;
   logic        lockErr;

   int vecCount;
   int errCount;

   int  mWord;
   int  mSent;
   int  mElapsed;
   int  mBit;
   int  mValid;
   int  mFrame;
   int  mLock;

   pn_bit_source dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .div         (div),
      .mode        (mode),
      .load        (load),
      .seed_in     (seedIn),
      .bit_out     (bitOut),
      .bit_valid   (bitValid),
      .frame_start (frameStart),
      .word_out    (wordOut),
      .lock_err    (lockErr)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic bit isPn(input int md);
      return (md != 1) && (md != 2);
   endfunction

   // Next word at a boundary, computed arithmetically from the mode rules.
   function automatic int nextWord(input int w, input int md, output int locked);
      int ones;
      locked = 0;
      if (md == 1) return w;
      if (md == 2) return ((w * 2) % 256) + (w / 128);
      if (w == 0) begin
         locked = 1;
         return SEED;
      end
      ones = 0;
      for (int k = 0; k < WIDTH; k++)
         if (((w & TAPSV) >> k) % 2 == 1) ones++;
      return ((w * 2) % 256) + (ones % 2);
   endfunction

   task automatic modelReset();
      mWord = SEED; mSent = 0; mElapsed = 0;
      mBit = 0; mValid = 0; mFrame = 0; mLock = 0;
   endtask

   // One clock edge of the reference behaviour for the given inputs.
   task automatic modelStep(input int en, input int ld, input int d,
                            input int md, input int s);
      int locked;
      mValid = 0;
      mFrame = 0;
      if (ld != 0) begin
         mWord    = (s == 0 && isPn(md)) ? SEED : s;
         mSent    = 0;
         mElapsed = 0;
      end else if (en != 0) begin
         if (mElapsed >= d) begin
            mBit     = (mWord >> (WIDTH - 1 - mSent)) % 2;
            mValid   = 1;
            mFrame   = (mSent == 0);
            mElapsed = 0;
            mSent++;
            if (mSent == WIDTH) begin
               mSent = 0;
               mWord = nextWord(mWord, md, locked);
               if (locked != 0) mLock = 1;
            end
         end else begin
            mElapsed++;
         end
      end
   endtask

   task automatic compareAll(input string tag);
      checkOutput({tag, ".bit_out"},     32'(bitOut),     32'(mBit));
      checkOutput({tag, ".bit_valid"},   32'(bitValid),   32'(mValid));
      checkOutput({tag, ".frame_start"}, 32'(frameStart), 32'(mFrame));
      checkOutput({tag, ".word_out"},    32'(wordOut),    32'(mWord));
      checkOutput({tag, ".lock_err"},    32'(lockErr),    32'(mLock));
   endtask

   // Drive one cycle of inputs, clock it, advance the model, then check.
   task automatic applyStimulus(input string tag, input logic en, input logic ld,
                                input logic [15:0] d, input logic [1:0] md,
                                input logic [7:0] s);
      enable = en; load = ld; div = d; mode = md; seedIn = s;
      @(posedge clk);
      modelStep(int'(en), int'(ld), int'(d), int'(md), int'(s));
      #1;
      compareAll(tag);
   endtask

   // Asynchronous reset asserted away from the clock edge; outputs must
   // reach their reset values before the next edge arrives.
   task automatic doReset(input string tag);
      rst = 1'b1;
      #1;
      modelReset();
      compareAll(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int strobes;
      logic [7:0] aaBits;
      vecCount = 0;
      errCount = 0;
      rst = 1'b1; enable = 1'b0; load = 1'b0; div = '0; mode = 2'b00; seedIn = '0;
      modelReset();
      @(posedge clk);
      #1;
      doReset("reset");

      // PN from reset at div=0: AA serialized, words AA -> 55 -> AB.
      aaBits = 8'hAA;
      for (int i = 0; i < 24; i++) begin
         applyStimulus("pn_div0", 1'b1, 1'b0, 16'd0, 2'b00, 8'h00);
         if (i < 8) checkOutput("pn_aa_bit", 32'(bitOut), 32'(aaBits[7 - i]));
         if (i == 0 || i == 8 || i == 16) checkOutput("pn_frame", 32'(frameStart), 32'd1);
         if (i == 7)  checkOutput("pn_word55", 32'(wordOut), 32'h55);
         if (i == 15) checkOutput("pn_wordAB", 32'(wordOut), 32'hAB);
      end

      // div=3: one strobe every 4 cycles, then a 5-cycle pause mid-word.
      doReset("reset2");
      strobes = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus("div3", 1'b1, 1'b0, 16'd3, 2'b00, 8'h00);
         if (bitValid) strobes++;
      end
      checkOutput("div3_strobes", 32'(strobes), 32'd10);
      for (int i = 0; i < 2; i++) applyStimulus("div3_pre", 1'b1, 1'b0, 16'd3, 2'b00, 8'h00);
      for (int i = 0; i < 5; i++) applyStimulus("pause", 1'b0, 1'b0, 16'd3, 2'b00, 8'h00);
      for (int i = 0; i < 8; i++) applyStimulus("resume", 1'b1, 1'b0, 16'd3, 2'b00, 8'h00);

      // REPEAT with zero word, then PN lockup recovery.
      applyStimulus("rep_load0", 1'b1, 1'b1, 16'd0, 2'b01, 8'h00);
      checkOutput("rep_word0", 32'(wordOut), 32'h00);
      for (int i = 0; i < 24; i++) begin
         applyStimulus("rep_run", 1'b1, 1'b0, 16'd0, 2'b01, 8'h00);
         if (bitValid) checkOutput("rep_zero_bit", 32'(bitOut), 32'd0);
      end
      checkOutput("rep_nolock", 32'(lockErr), 32'd0);
      for (int i = 0; i < 8; i++) applyStimulus("lock_pn", 1'b1, 1'b0, 16'd0, 2'b00, 8'h00);
      checkOutput("lock_wordAA", 32'(wordOut), 32'hAA);
      checkOutput("lock_flag", 32'(lockErr), 32'd1);
      applyStimulus("lock_load", 1'b1, 1'b1, 16'd0, 2'b00, 8'h3C);
      checkOutput("lock_sticky", 32'(lockErr), 32'd1);

      // PN zero-seed substitution and load overriding a tick.
      doReset("reset3");
      applyStimulus("pn_load0", 1'b1, 1'b1, 16'd0, 2'b00, 8'h00);
      checkOutput("pn_load0_word", 32'(wordOut), 32'hAA);
      checkOutput("pn_load0_lock", 32'(lockErr), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus("pn_run", 1'b1, 1'b0, 16'd0, 2'b00, 8'h00);
      applyStimulus("load_tick", 1'b1, 1'b1, 16'd0, 2'b00, 8'h5A);
      checkOutput("load_tick_valid", 32'(bitValid), 32'd0);
      applyStimulus("after_load", 1'b1, 1'b0, 16'd0, 2'b00, 8'h00);
      checkOutput("after_load_frame", 32'(frameStart), 32'd1);

      // ROTATE 81 -> 03 -> 06, then reset mid-word.
      applyStimulus("rot_load", 1'b1, 1'b1, 16'd0, 2'b10, 8'h81);
      for (int i = 0; i < 8; i++) applyStimulus("rot_run", 1'b1, 1'b0, 16'd0, 2'b10, 8'h00);
      checkOutput("rot_word03", 32'(wordOut), 32'h03);
      for (int i = 0; i < 8; i++) applyStimulus("rot_run", 1'b1, 1'b0, 16'd0, 2'b10, 8'h00);
      checkOutput("rot_word06", 32'(wordOut), 32'h06);
      for (int i = 0; i < 3; i++) applyStimulus("rot_mid", 1'b1, 1'b0, 16'd0, 2'b10, 8'h00);
      doReset("reset_mid");
      checkOutput("reset_mid_word", 32'(wordOut), 32'hAA);

      // Randomized mix of every control input.
      for (int i = 0; i < 600; i++) begin
         logic en, ld;
         logic [15:0] d;
         logic [1:0] md;
         logic [7:0] s;
         en = ($urandom_range(0, 9) < 8);
         ld = ($urandom_range(0, 19) == 0);
         d  = 16'($urandom_range(0, 3));
         md = 2'($urandom_range(0, 3));
         s  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 149) == 0) doReset("rnd_reset");
         else applyStimulus("rnd", en, ld, d, md, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/pn_bit_source.md
PN_BIT_SOURCE -- requirements
Module: pn_bit_source

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LFSR/word width (legal 4..32).
REQ-002 SHALL have parameter TAPS, default 8'h8E, feedback mask; bit k set = word[k] in XOR.
REQ-003 SHALL have parameter SEED, default 8'hAA, reset/recovery word; nonzero required.
REQ-004 SHALL have parameter DIV_W, default 16, width of bit-period divisor.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  1 = run divider/serializer, 0 = freeze all state.
REQ-008 SHALL have port div  in  DIV_W  bit period minus 1, in clk cycles.
REQ-009 SHALL have port mode  in  2  00 PN, 01 REPEAT, 10 ROTATE, 11 reserved (treated as PN).
REQ-010 SHALL have port load  in  1  synchronous seed load strobe.
REQ-011 SHALL have port seed_in  in  WIDTH  word loaded on load.
REQ-012 SHALL have port bit_out  out  1  current serial code bit, registered.
REQ-013 SHALL have port bit_valid  out  1  one-cycle strobe per new bit_out.
REQ-014 SHALL have port frame_start  out  1  with bit_valid, marks the first (MSB) bit of a word.
REQ-015 SHALL have port word_out  out  WIDTH  word currently being serialized.
REQ-016 SHALL have port lock_err  out  1  sticky all-zero lockup flag.

Function
REQ-017 SHALL hold internal state: word, bit index idx (WIDTH-1 down to 0), divider cnt (DIV_W bits).
REQ-018 SHALL generate tick when enable=1 and cnt>=div; cnt then clears to 0, else cnt increments.
REQ-019 SHALL, when div=0, tick every enabled cycle.
REQ-020 SHALL, when div changes mid-period, apply the new value on the next compare; cnt>div ticks immediately.
REQ-021 SHALL, on tick, register bit_out<=word[idx], pulse bit_valid for 1 cycle, frame_start=1 iff idx==WIDTH-1.
REQ-022 SHALL, on tick with idx!=0, decrement idx; word unchanged.
REQ-023 SHALL, on tick with idx==0, set idx<=WIDTH-1 and advance word per mode sampled that cycle.
REQ-024 SHALL advance in PN: word<={word[WIDTH-2:0], ^(word & TAPS)}.
REQ-025 SHALL advance in REPEAT: word unchanged.
REQ-026 SHALL advance in ROTATE: word<={word[WIDTH-2:0], word[WIDTH-1]}.
REQ-027 SHALL, at PN advance with word==0, load SEED instead and set lock_err (held until rst).
REQ-028 SHALL, on load=1, set word<=seed_in (SEED if seed_in==0 and mode is PN), idx<=WIDTH-1, cnt<=0, bit_valid=0, frame_start=0, bit_out held; load overrides a coincident tick.
REQ-029 SHALL, when enable=0 and load=0, hold word, idx, cnt, bit_out; bit_valid=frame_start=0.
REQ-030 SHALL drive word_out directly from the word register.
REQ-031 SHALL have no combinational path from inputs to outputs.

Reset
REQ-032 SHALL, on rst=1 (asynchronous, any time incl. mid-word), force word=SEED, idx=WIDTH-1, cnt=0, bit_out=0, bit_valid=0, frame_start=0, lock_err=0.
REQ-033 SHALL, after rst release, emit the first tick div+1 enabled cycles later, being word[WIDTH-1] with frame_start=1.

Verification (defaults WIDTH=8, TAPS=8'h8E, SEED=8'hAA)
REQ-034 SHALL cover: rst, div=0, mode=PN, enable=1 -> bit_out 1,0,1,0,1,0,1,0 on consecutive cycles; word_out AA->55->AB at word boundaries; frame_start on bits 0, 8, 16.
REQ-035 SHALL cover: div=3, enable=1 -> bit_valid exactly every 4th cycle; enable low for 5 cycles mid-word -> no strobes, same bit resumes with remaining cnt.
REQ-036 SHALL cover: mode=REPEAT, load seed_in=8'h00, run 3 words -> 24 zero bits, lock_err=0; switch to PN -> at next boundary word_out=AA, lock_err=1 until rst.
REQ-037 SHALL cover: mode=PN, load seed_in=8'h00 -> word_out=AA, lock_err=0; load coincident with tick -> no bit_valid, idx restarts at 7.
REQ-038 SHALL cover: mode=ROTATE, load 8'h81 -> words 81, 03, 06; rst asserted mid-word -> outputs at reset values that same cycle.
